// File: rtl/addsub_seq_pkg.sv
// addsub_seq_pkg: shared FSM encodings, operation modes and sizing helper for addsub_seq
package addsub_seq_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/addsub_seq_if.sv
// addsub_seq_if: start/done handshake, operands, result and status flags of addsub_seq
interface addsub_seq_if #(parameter int WIDTH = 16);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    modport master (output start, mode, a, b, input busy, done, result, carry, overflow, zero, negative);
    modport slave  (input start, mode, a, b, output busy, done, result, carry, overflow, zero, negative);
endinterface

// File: rtl/addsub_seq_chunk_adder.sv
// chunk_adder: CHUNK-bit ripple adder built from full_adder_1bit cells
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunk_adder #(parameter int CHUNK = 4) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK:0] c;
    assign c[0] = cin;
    assign cout = c[CHUNK];
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder_1bit u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .sum(sum[i]), .cout(c[i+1]));
    end
endmodule

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle add/subtract, CHUNK bits per clock with registered ripple carry and flags
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    addsub_seq_if.slave  bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = idx_width(N);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("addsub_seq: WIDTH must be a multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             cr_q, cr_d, carry_q, carry_d, ovf_q, ovf_d;
    logic             zero_q, zero_d, neg_q, neg_d, done_q, done_d, busy_q, busy_d;
    logic [CHUNK-1:0] ca, cb, cs;
    logic             co;

    assign ca = a_q[int'(k_q)*CHUNK +: CHUNK];
    assign cb = b_q[int'(k_q)*CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (.a(ca), .b(cb), .cin(cr_q), .sum(cs), .cout(co));

    // next state: accept in IDLE/DONE, ripple one chunk per RUN cycle, publish flags on the last chunk
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        cr_d    = cr_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        if (state_q == ST_RUN) begin
            res_d[int'(k_q)*CHUNK +: CHUNK] = cs;
            cr_d = co;
            if (k_q == KW'(N - 1)) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                carry_d = co;
                ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
                zero_d  = (res_d == '0);
                neg_d   = res_d[WIDTH-1];
            end else begin
                k_d    = k_q + KW'(1);
                busy_d = 1'b1;
            end
        end else if (bus.start) begin
            state_d = ST_RUN;
            k_d     = '0;
            a_d     = bus.a;
            b_d     = bus.b ^ {WIDTH{bus.mode == MODE_SUB}};
            cr_d    = (bus.mode != MODE_ADD);
            busy_d  = 1'b1;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // state, operand and output registers; reset aborts any operation and clears every output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cr_q    <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cr_q    <= cr_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = res_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
    assign bus.negative = neg_q;
endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed checks of addsub_seq with CHUNK=4, plus CHUNK=1 and CHUNK=16 instances
module tb_addsub_seq;
    import addsub_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = MODE_ADD;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    addsub_seq_if #(.WIDTH(16)) i4 ();
    addsub_seq_if #(.WIDTH(16)) i1 ();
    addsub_seq_if #(.WIDTH(16)) i16 ();

    assign i4.start  = start;
    assign i4.mode   = mode;
    assign i4.a      = a;
    assign i4.b      = b;
    assign i1.start  = start;
    assign i1.mode   = mode;
    assign i1.a      = a;
    assign i1.b      = b;
    assign i16.start = start;
    assign i16.mode  = mode;
    assign i16.a     = a;
    assign i16.b     = b;

    addsub_seq #(.WIDTH(16), .CHUNK(4))  u4  (.clk(clk), .rst(rst), .bus(i4.slave));
    addsub_seq #(.WIDTH(16), .CHUNK(1))  u1  (.clk(clk), .rst(rst), .bus(i1.slave));
    addsub_seq #(.WIDTH(16), .CHUNK(16)) u16 (.clk(clk), .rst(rst), .bus(i16.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] r, input logic c, input logic o,
                           input logic z, input logic n);
        chk({tag, "_result"}, 32'(i4.result), 32'(r));
        chk({tag, "_carry"}, 32'(i4.carry), 32'(c));
        chk({tag, "_overflow"}, 32'(i4.overflow), 32'(o));
        chk({tag, "_zero"}, 32'(i4.zero), 32'(z));
        chk({tag, "_negative"}, 32'(i4.negative), 32'(n));
    endtask

    // start one op; n counts cycles after the accepting edge until done (or the bound)
    task automatic op(input string tag, input logic m, input logic [15:0] x, input logic [15:0] y,
                      output int n);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        chk({tag, "_busy_t1"}, 32'(i4.busy), 32'd1);
        chk({tag, "_done_t1"}, 32'(i4.done), 32'd0);
        while (!i4.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_at_done"}, 32'(i4.busy), 32'd0);
    endtask

    initial begin
        int n, n1, n16, seen;
        #2;
        chk("reset_busy", 32'(i4.busy), 32'd0);
        chk("reset_done", 32'(i4.done), 32'd0);
        chk_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        op("add", MODE_ADD, 16'h1234, 16'h4321, n);
        chk("add_latency", 32'(n), 32'd5);
        chk_out("add", 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);

        op("sub_borrow", MODE_SUB, 16'h0005, 16'h0007, n);
        chk("sub_borrow_latency", 32'(n), 32'd5);
        chk_out("sub_borrow", 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);

        op("ovf", MODE_ADD, 16'h7FFF, 16'h0001, n);
        chk("ovf_latency", 32'(n), 32'd5);
        chk_out("ovf", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);

        op("wrap", MODE_ADD, 16'hFFFF, 16'h0001, n);
        chk("wrap_latency", 32'(n), 32'd5);
        chk_out("wrap", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        chk("hold_after_done", 32'(i4.result), 32'h0000);
        chk("hold_zero", 32'(i4.zero), 32'd1);

        // start pulsed mid-RUN with other operands must be ignored
        @(negedge clk);
        start = 1'b1;
        mode  = MODE_ADD;
        a     = 16'h1000;
        b     = 16'h0234;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        @(negedge clk);
        n++;
        start = 1'b1;
        mode  = MODE_SUB;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        @(negedge clk);
        n++;
        start = 1'b0;
        chk("ign_busy", 32'(i4.busy), 32'd1);
        chk("ign_flags_held", 32'(i4.zero), 32'd1);
        while (!i4.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ign_latency", 32'(n), 32'd5);
        chk_out("ign", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);

        // back-to-back: start held high through RUN and DONE
        @(negedge clk);
        start = 1'b1;
        mode  = MODE_ADD;
        a     = 16'h1111;
        b     = 16'h2222;
        @(negedge clk);
        mode = MODE_SUB;
        a    = 16'h0100;
        b    = 16'h0001;
        n    = 1;
        while (!i4.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_latency", 32'(n), 32'd5);
        chk_out("b2b_first", 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("b2b_busy_after_done", 32'(i4.busy), 32'd1);
                start = 1'b0;
            end
        end while (!i4.done && n < 40);
        chk("b2b_done_gap", 32'(n), 32'd5);
        chk_out("b2b_second", 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset two cycles into an operation
        @(negedge clk);
        start = 1'b1;
        mode  = MODE_ADD;
        a     = 16'hAAAA;
        b     = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(i4.busy), 32'd0);
        chk("rst_mid_done", 32'(i4.done), 32'd0);
        chk_out("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i4.done) seen++;
        end
        chk("rst_no_done", 32'(seen), 32'd0);

        op("post_rst", MODE_ADD, 16'hAAAA, 16'h1111, n);
        chk("post_rst_latency", 32'(n), 32'd5);
        chk_out("post_rst", 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b1);

        // CHUNK sweep: all instances start together from reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        mode  = MODE_SUB;
        a     = 16'h8000;
        b     = 16'h0001;
        n1    = 0;
        n16   = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i1.done && n1 == 0) n1 = i;
            if (i16.done && n16 == 0) n16 = i;
        end
        chk("c1_latency", 32'(n1), 32'd17);
        chk("c16_latency", 32'(n16), 32'd2);
        chk("c1_result", 32'(i1.result), 32'h7FFF);
        chk("c1_overflow", 32'(i1.overflow), 32'd1);
        chk("c1_carry", 32'(i1.carry), 32'd1);
        chk("c16_result", 32'(i16.result), 32'h7FFF);
        chk("c16_overflow", 32'(i16.overflow), 32'd1);
        chk("c16_carry", 32'(i16.carry), 32'd1);
        chk_out("c4", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
